// File: rtl/riscv_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states, read owner.
package riscv_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } acc_size_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } owner_t;

  // Bytes touched by an access; the unused encoding 2'b11 is treated as a word so
  // that the range check stays conservative.
  function automatic logic [2:0] size_bytes(acc_size_t sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, debug and memory-command signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
) ();
  import riscv_pkg::*;

  logic              core_req;
  logic              core_we;
  acc_size_t         core_size;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_stall;
  logic [31:0]       core_rdata;
  logic              core_rvalid;

  logic              dbg_valid;
  logic              dbg_ready;
  logic              dbg_we;
  acc_size_t         dbg_size;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dbg_rvalid;

  logic              mem_en;
  logic              mem_we;
  acc_size_t         mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_size, core_addr, core_wdata,
    output core_stall, core_rdata, core_rvalid,
    input  dbg_valid, dbg_we, dbg_size, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Pipeline / debugger / memory side.
  modport master (
    output core_req, core_we, core_size, core_addr, core_wdata,
    input  core_stall, core_rdata, core_rvalid,
    output dbg_valid, dbg_we, dbg_size, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts cycles a debug request has been refused; sat forces the debug port through.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Saturating up-count, cleared on handshake or reset.
  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != W'(MAX)))
      cnt <= cnt + W'(1);
  end

  assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core MEM stage has priority, debug port is bounded by a
// starvation counter. Reads take a grant cycle plus one data cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrate, issue at most one memory command
// RD_WAIT | memory data returning, routed to the registered owner
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int MEM_BYTES  = 648,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  // Extra headroom so addr + 4 never wraps in the range check.
  localparam int CHK_W = ADDR_W + 2;

  arb_state_t        state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              rd_oor, rd_oor_nxt;
  logic [31:0]       core_rdata_q, dbg_rdata_q;
  logic              dbg_win, core_win, grant, in_range, starve_sat;
  logic              sel_we;
  acc_size_t         sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [CHK_W-1:0]  end_addr;
  logic [31:0]       rd_data;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (bus.dbg_valid && !bus.dbg_ready),
    .clr (dbg_win),
    .sat (starve_sat)
  );

  // Arbitration, memory command, next state and pipeline-facing outputs.
  always_comb begin
    dbg_win    = 1'b0;
    core_win   = 1'b0;
    if (state == IDLE) begin
      if (bus.dbg_valid && (starve_sat || !bus.core_req))
        dbg_win = 1'b1;
      else if (bus.core_req)
        core_win = 1'b1;
    end
    grant = dbg_win || core_win;

    sel_we    = dbg_win ? bus.dbg_we    : bus.core_we;
    sel_size  = dbg_win ? bus.dbg_size  : bus.core_size;
    sel_addr  = dbg_win ? bus.dbg_addr  : bus.core_addr;
    sel_wdata = dbg_win ? bus.dbg_wdata : bus.core_wdata;

    end_addr = CHK_W'(sel_addr) + CHK_W'(size_bytes(sel_size));
    in_range = (end_addr <= CHK_W'(MEM_BYTES));

    // Out-of-range accesses are still granted; only the memory strobe is suppressed.
    bus.mem_en    = grant && in_range;
    bus.mem_we    = grant && in_range && sel_we;
    bus.mem_size  = sel_size;
    bus.mem_addr  = sel_addr;
    bus.mem_wdata = sel_wdata;

    state_nxt  = IDLE;
    owner_nxt  = owner;
    rd_oor_nxt = rd_oor;
    if (grant && !sel_we) begin
      state_nxt  = RD_WAIT;
      owner_nxt  = dbg_win ? DBG : CORE;
      rd_oor_nxt = !in_range;
    end

    bus.dbg_ready = dbg_win;

    // rvalid is masked while reset is asserted so a discarded read never completes.
    rd_data         = rd_oor ? 32'h0 : bus.mem_rdata;
    bus.core_rvalid = (state == RD_WAIT) && (owner == CORE) && rst;
    bus.dbg_rvalid  = (state == RD_WAIT) && (owner == DBG) && rst;
    bus.core_rdata  = bus.core_rvalid ? rd_data : core_rdata_q;
    bus.dbg_rdata   = bus.dbg_rvalid  ? rd_data : dbg_rdata_q;

    bus.core_stall = 1'b0;
    if (bus.core_req) begin
      if (state == IDLE)
        bus.core_stall = !core_win || !bus.core_we;
      else
        bus.core_stall = (owner != CORE);
    end
  end

  // FSM state, read owner and held load data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= CORE;
      rd_oor       <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      rd_oor       <= rd_oor_nxt;
      core_rdata_q <= bus.core_rdata;
      dbg_rdata_q  <= bus.dbg_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural byte memory.
module tb_dmem_arbiter;
  import riscv_pkg::*;

  localparam int MEMB = 648;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0]  mem_arr [0:MEMB-1];
  logic [7:0]  ref_mem [0:MEMB-1];
  logic [31:0] core_q[$];
  logic [31:0] dbg_q[$];

  dmem_arbiter_if #(.ADDR_W(10)) bus ();

  dmem_arbiter #(.MEM_BYTES(MEMB), .ADDR_W(10), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nbytes(acc_size_t s);
    return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
  endfunction

  // Behavioural memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int k = 0; k < nbytes(bus.mem_size); k++)
          if (int'(bus.mem_addr) + k < MEMB)
            mem_arr[int'(bus.mem_addr) + k] <= bus.mem_wdata[8*k +: 8];
      end else begin
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < nbytes(bus.mem_size); k++)
          if (int'(bus.mem_addr) + k < MEMB)
            w[8*k +: 8] = mem_arr[int'(bus.mem_addr) + k];
        bus.mem_rdata <= w;
      end
    end
  end

  function automatic logic [31:0] exp_read(input int a, input acc_size_t s);
    logic [31:0] w;
    w = '0;
    if (a + nbytes(s) <= MEMB)
      for (int k = 0; k < nbytes(s); k++) w[8*k +: 8] = ref_mem[a + k];
    return w;
  endfunction

  task automatic ref_write(input int a, input acc_size_t s, input logic [31:0] d);
    if (a + nbytes(s) <= MEMB)
      for (int k = 0; k < nbytes(s); k++) ref_mem[a + k] = d[8*k +: 8];
  endtask

  // Completion monitor: every rvalid pops one expected load result.
  always @(negedge clk) begin
    if (bus.core_rvalid) begin
      if (core_q.size() == 0) chk("core_rvalid_unexpected", 32'd1, 32'd0);
      else chk("core_rdata", bus.core_rdata, core_q.pop_front());
    end
    if (bus.dbg_rvalid) begin
      if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 32'd1, 32'd0);
      else chk("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_core(input logic req, input logic we, input acc_size_t s,
                            input logic [9:0] a, input logic [31:0] d);
    bus.core_req = req; bus.core_we = we; bus.core_size = s;
    bus.core_addr = a;  bus.core_wdata = d;
  endtask

  task automatic drive_dbg(input logic v, input logic we, input acc_size_t s,
                           input logic [9:0] a, input logic [31:0] d);
    bus.dbg_valid = v; bus.dbg_we = we; bus.dbg_size = s;
    bus.dbg_addr = a;  bus.dbg_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.mem_rdata = '0;
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    drive_dbg(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);

    // Reset state
    tick(); tick();
    sample();
    chk("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
    chk("rst_core_rdata", bus.core_rdata, 32'h0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
    chk("rst_starve", 32'(dut.u_starve.cnt), 32'd0);
    chk("rst_stall", 32'(bus.core_stall), 32'd0);
    tick();
    rst = 1'b1;

    // 1: core SW then LW at 4
    drive_core(1'b1, 1'b1, SZ_W, 10'd4, 32'h0F0F0F0D);
    ref_write(4, SZ_W, 32'h0F0F0F0D);
    sample();
    chk("t1_sw_mem_we", 32'(bus.mem_we), 32'd1);
    chk("t1_sw_stall", 32'(bus.core_stall), 32'd0);
    tick();
    drive_core(1'b1, 1'b0, SZ_W, 10'd4, 32'h0);
    core_q.push_back(exp_read(4, SZ_W));
    sample();
    chk("t1_lw_stall", 32'(bus.core_stall), 32'd1);
    chk("t1_lw_mem_en", 32'(bus.mem_en), 32'd1);
    tick();
    sample();
    chk("t1_rd_rvalid", 32'(bus.core_rvalid), 32'd1);
    chk("t1_rd_stall", 32'(bus.core_stall), 32'd0);
    tick();
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);

    // 2: core writes every cycle while dbg holds a write
    drive_dbg(1'b1, 1'b1, SZ_W, 10'd8, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      drive_core(1'b1, 1'b1, SZ_W, 10'd12, 32'h10000000 + i);
      if (i < 4) ref_write(12, SZ_W, 32'h10000000 + i);
      else ref_write(8, SZ_W, 32'hDEADBEEF);
      sample();
      chk($sformatf("t2_dbg_ready_c%0d", i), 32'(bus.dbg_ready), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t2_stall_c%0d", i), 32'(bus.core_stall), (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) chk("t2_starve_sat", 32'(dut.u_starve.cnt), 32'd4);
      tick();
    end
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    drive_dbg(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    sample();
    chk("t2_starve_clr", 32'(dut.u_starve.cnt), 32'd0);
    tick();

    // 3: dbg SH then LH at 16, core idle
    drive_dbg(1'b1, 1'b1, SZ_H, 10'd16, 32'h0000FFC0);
    ref_write(16, SZ_H, 32'h0000FFC0);
    sample();
    chk("t3_sh_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    drive_dbg(1'b1, 1'b0, SZ_H, 10'd16, 32'h0);
    dbg_q.push_back(exp_read(16, SZ_H));
    sample();
    chk("t3_lh_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    drive_dbg(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    sample();
    chk("t3_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    tick();

    // 4: dbg raised while core read is in RD_WAIT
    drive_core(1'b1, 1'b0, SZ_W, 10'd12, 32'h0);
    core_q.push_back(exp_read(12, SZ_W));
    tick();
    drive_dbg(1'b1, 1'b0, SZ_W, 10'd8, 32'h0);
    sample();
    chk("t4_rdwait_ready", 32'(bus.dbg_ready), 32'd0);
    chk("t4_core_rvalid", 32'(bus.core_rvalid), 32'd1);
    tick();
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    dbg_q.push_back(exp_read(8, SZ_W));
    sample();
    chk("t4_dbg_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    drive_dbg(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    sample();
    chk("t4_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    tick();

    // 5: range boundary and out-of-range accesses
    drive_core(1'b1, 1'b1, SZ_W, 10'd644, 32'h11223344);
    ref_write(644, SZ_W, 32'h11223344);
    sample();
    chk("t5_sw644_en", 32'(bus.mem_en), 32'd1);
    tick();
    drive_core(1'b1, 1'b0, SZ_W, 10'd646, 32'h0);
    core_q.push_back(32'h0);
    sample();
    chk("t5_lw646_en", 32'(bus.mem_en), 32'd0);
    chk("t5_lw646_stall", 32'(bus.core_stall), 32'd1);
    tick();
    sample();
    chk("t5_lw646_rvalid", 32'(bus.core_rvalid), 32'd1);
    tick();
    drive_core(1'b1, 1'b1, SZ_B, 10'd700, 32'h000000AA);
    ref_write(700, SZ_B, 32'h000000AA);
    sample();
    chk("t5_sb700_en", 32'(bus.mem_en), 32'd0);
    chk("t5_sb700_we", 32'(bus.mem_we), 32'd0);
    chk("t5_sb700_stall", 32'(bus.core_stall), 32'd0);
    tick();
    drive_core(1'b1, 1'b0, SZ_W, 10'd644, 32'h0);
    core_q.push_back(exp_read(644, SZ_W));
    sample();
    chk("t5_lw644_en", 32'(bus.mem_en), 32'd1);
    tick();
    sample();
    chk("t5_lw644_rvalid", 32'(bus.core_rvalid), 32'd1);
    tick();
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    tick();

    // 6: reset during RD_WAIT discards the read
    drive_core(1'b1, 1'b0, SZ_W, 10'd4, 32'h0);
    drive_dbg(1'b1, 1'b1, SZ_B, 10'd20, 32'h55);
    core_q.push_back(exp_read(4, SZ_W));
    sample();
    chk("t6_lw_stall", 32'(bus.core_stall), 32'd1);
    tick();
    rst = 1'b0;
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    core_q.delete();
    sample();
    chk("t6_rst_rvalid", 32'(bus.core_rvalid), 32'd0);
    tick();
    drive_dbg(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    sample();
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    chk("t6_starve", 32'(dut.u_starve.cnt), 32'd0);
    chk("t6_no_rvalid", 32'(bus.core_rvalid), 32'd0);
    tick();
    rst = 1'b1;
    drive_core(1'b1, 1'b0, SZ_W, 10'd4, 32'h0);
    core_q.push_back(exp_read(4, SZ_W));
    sample();
    chk("t6_relw_stall", 32'(bus.core_stall), 32'd1);
    tick();
    sample();
    chk("t6_relw_rvalid", 32'(bus.core_rvalid), 32'd1);
    chk("t6_relw_stall2", 32'(bus.core_stall), 32'd0);
    tick();
    drive_core(1'b0, 1'b0, SZ_W, 10'd0, 32'h0);
    tick(); tick();

    chk("core_q_drained", 32'(core_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
